// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared scancode prefixes, key event record and decoder states
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // One decoded key event as stored in the queue; packs to {release, extended, code}
  typedef struct packed {
    logic       released;
    logic       extended;
    logic [7:0] code;
  } key_evt_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } dec_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word-fall-through FIFO with wrap-bit pointers
module sync_fifo_fwft #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    wr_ptr;
  logic [CW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra MSB on each pointer distinguishes full from empty when the index bits match
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[CW-2:0] == rd_ptr[CW-2:0]) & (wr_ptr[CW-1] != rd_ptr[CW-1]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign count   = wr_ptr - rd_ptr;

  // Head entry is presented combinationally; zeros when nothing is queued
  assign pop_data = empty ? '0 : mem[rd_ptr[CW-2:0]];

  // Pointer advance; simultaneous push and pop leave the occupancy unchanged
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until written so no reset is needed
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[CW-2:0]] <= push_data;
  end

endmodule

// File: rtl/ps2_key_event_queue.sv
// rtl/ps2_key_event_queue.sv - PS/2 scancode decoder feeding an MMIO event queue
module ps2_key_event_queue
  import ps2_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          KEY_STROBE,
  input  logic [7:0]    KEY_CODE,
  input  logic          RD_EN,
  output logic [10:0]   RD_DATA,
  output logic          INTR,
  output logic          OVERFLOW,
  input  logic          CLR_OVF,
  output logic [CW-1:0] COUNT
);

  logic       strobe_q;
  logic       byte_evt;
  dec_state_t state;
  dec_state_t state_n;
  logic       evt_push;
  key_evt_t   evt;
  key_evt_t   head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       drop;

  // Driver holds the strobe for several cycles; only its rising edge carries a byte
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) strobe_q <= 1'b0;
    else       strobe_q <= KEY_STROBE;
  end

  assign byte_evt = KEY_STROBE & ~strobe_q;

  // Decoder state register; reset discards any half-received prefix sequence
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Fold E0/F0 prefixes into flags and emit an event on the terminating code byte
  always_comb begin
    state_n      = state;
    evt_push     = 1'b0;
    evt.released = 1'b0;
    evt.extended = 1'b0;
    evt.code     = KEY_CODE;
    if (byte_evt) begin
      case (state)
        ST_IDLE: begin
          if (KEY_CODE == PS2_EXT)      state_n = ST_EXT;
          else if (KEY_CODE == PS2_BRK) state_n = ST_BRK;
          else                          evt_push = 1'b1;
        end
        ST_EXT: begin
          if (KEY_CODE == PS2_BRK) state_n = ST_EXT_BRK;
          else if (KEY_CODE != PS2_EXT) begin
            evt_push     = 1'b1;
            evt.extended = 1'b1;
            state_n      = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (KEY_CODE == PS2_EXT) state_n = ST_EXT_BRK;
          else if (KEY_CODE != PS2_BRK) begin
            evt_push     = 1'b1;
            evt.released = 1'b1;
            state_n      = ST_IDLE;
          end
        end
        default: begin
          if (KEY_CODE != PS2_EXT && KEY_CODE != PS2_BRK) begin
            evt_push     = 1'b1;
            evt.released = 1'b1;
            evt.extended = 1'b1;
            state_n      = ST_IDLE;
          end
        end
      endcase
    end
  end

  sync_fifo_fwft #(
    .WIDTH ($bits(key_evt_t)),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .CLK       (CLK),
    .reset     (reset),
    .push      (evt_push),
    .push_data (evt),
    .pop       (RD_EN),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (COUNT)
  );

  // A full queue is never empty, so RD_EN alone tells whether room opens this cycle
  assign drop = evt_push & fifo_full & ~RD_EN;

  // Sticky overflow; a fresh drop outranks a coincident clear
  always_ff @(posedge CLK or posedge reset) begin
    if (reset)        OVERFLOW <= 1'b0;
    else if (drop)    OVERFLOW <= 1'b1;
    else if (CLR_OVF) OVERFLOW <= 1'b0;
  end

  assign INTR    = ~fifo_empty;
  assign RD_DATA = {~fifo_empty, head};

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// tb/tb_ps2_key_event_queue.sv - directed self-checking bench for the key event queue
module tb_ps2_key_event_queue;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        KEY_STROBE = 1'b0;
  logic [7:0]  KEY_CODE = 8'h00;
  logic        RD_EN = 1'b0;
  logic [10:0] RD_DATA;
  logic        INTR;
  logic        OVERFLOW;
  logic        CLR_OVF = 1'b0;
  logic [4:0]  COUNT;

  int total = 0;
  int bad = 0;

  ps2_key_event_queue #(.DEPTH(16), .CW(5)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .KEY_STROBE (KEY_STROBE),
    .KEY_CODE   (KEY_CODE),
    .RD_EN      (RD_EN),
    .RD_DATA    (RD_DATA),
    .INTR       (INTR),
    .OVERFLOW   (OVERFLOW),
    .CLR_OVF    (CLR_OVF),
    .COUNT      (COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b1;
    KEY_STROBE = 1'b0;
    RD_EN = 1'b0;
    CLR_OVF = 1'b0;
    @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
  endtask

  task automatic send_byte(input logic [7:0] code, input int len);
    KEY_CODE = code;
    KEY_STROBE = 1'b1;
    repeat (len) @(negedge CLK);
    KEY_STROBE = 1'b0;
    @(negedge CLK);
  endtask

  task automatic pop_one();
    RD_EN = 1'b1;
    @(negedge CLK);
    RD_EN = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (RD_DATA !== 11'h000) begin bad++; $display("FAIL reset_rd_data got=%h exp=000", RD_DATA); end
    total++; if (INTR !== 1'b0) begin bad++; $display("FAIL reset_intr got=%b exp=0", INTR); end
    total++; if (OVERFLOW !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", OVERFLOW); end
    total++; if (COUNT !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", COUNT); end
  endtask

  task automatic test_long_strobe();
    do_reset();
    KEY_CODE = 8'h1C;
    KEY_STROBE = 1'b1;
    @(negedge CLK);
    total++; if (INTR !== 1'b1) begin bad++; $display("FAIL hold_intr_latency got=%b exp=1", INTR); end
    total++; if (COUNT !== 5'd1) begin bad++; $display("FAIL hold_count_latency got=%0d exp=1", COUNT); end
    repeat (6) @(negedge CLK);
    KEY_STROBE = 1'b0;
    @(negedge CLK);
    total++; if (COUNT !== 5'd1) begin bad++; $display("FAIL hold_count got=%0d exp=1", COUNT); end
    total++; if (RD_DATA !== 11'h41C) begin bad++; $display("FAIL hold_rd_data got=%h exp=41C", RD_DATA); end
    pop_one();
    total++; if (COUNT !== 5'd0) begin bad++; $display("FAIL hold_pop_count got=%0d exp=0", COUNT); end
  endtask

  task automatic test_break();
    do_reset();
    send_byte(8'hF0, 3);
    total++; if (COUNT !== 5'd0) begin bad++; $display("FAIL brk_prefix_count got=%0d exp=0", COUNT); end
    total++; if (INTR !== 1'b0) begin bad++; $display("FAIL brk_prefix_intr got=%b exp=0", INTR); end
    send_byte(8'h1C, 2);
    total++; if (COUNT !== 5'd1) begin bad++; $display("FAIL brk_count got=%0d exp=1", COUNT); end
    total++; if (RD_DATA !== 11'h61C) begin bad++; $display("FAIL brk_rd_data got=%h exp=61C", RD_DATA); end
    pop_one();
  endtask

  task automatic test_extended();
    do_reset();
    send_byte(8'hE0, 1);
    send_byte(8'h75, 1);
    send_byte(8'hE0, 1);
    send_byte(8'hF0, 1);
    send_byte(8'h75, 1);
    send_byte(8'hE0, 1);
    send_byte(8'hE0, 1);
    send_byte(8'h6B, 1);
    total++; if (COUNT !== 5'd3) begin bad++; $display("FAIL ext_count got=%0d exp=3", COUNT); end
    total++; if (RD_DATA !== 11'h575) begin bad++; $display("FAIL ext_first got=%h exp=575", RD_DATA); end
    pop_one();
    total++; if (RD_DATA !== 11'h775) begin bad++; $display("FAIL ext_brk_second got=%h exp=775", RD_DATA); end
    total++; if (INTR !== 1'b1) begin bad++; $display("FAIL ext_intr_mid got=%b exp=1", INTR); end
    pop_one();
    total++; if (RD_DATA !== 11'h56B) begin bad++; $display("FAIL ext_repeat_prefix got=%h exp=56B", RD_DATA); end
    pop_one();
    total++; if (INTR !== 1'b0) begin bad++; $display("FAIL ext_intr_fall got=%b exp=0", INTR); end
    total++; if (RD_DATA !== 11'h000) begin bad++; $display("FAIL ext_empty_data got=%h exp=000", RD_DATA); end
  endtask

  task automatic test_overflow();
    logic [10:0] exp_head;
    do_reset();
    for (int i = 1; i <= 17; i++) send_byte(8'(i), 1);
    total++; if (COUNT !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", COUNT); end
    total++; if (OVERFLOW !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", OVERFLOW); end
    total++; if (RD_DATA !== 11'h401) begin bad++; $display("FAIL ovf_head got=%h exp=401", RD_DATA); end
    CLR_OVF = 1'b1;
    @(negedge CLK);
    CLR_OVF = 1'b0;
    total++; if (OVERFLOW !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", OVERFLOW); end
    KEY_CODE = 8'h12;
    KEY_STROBE = 1'b1;
    CLR_OVF = 1'b1;
    @(negedge CLK);
    CLR_OVF = 1'b0;
    KEY_STROBE = 1'b0;
    total++; if (OVERFLOW !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got=%b exp=1", OVERFLOW); end
    @(negedge CLK);
    CLR_OVF = 1'b1;
    @(negedge CLK);
    CLR_OVF = 1'b0;
    KEY_CODE = 8'h13;
    KEY_STROBE = 1'b1;
    RD_EN = 1'b1;
    @(negedge CLK);
    RD_EN = 1'b0;
    KEY_STROBE = 1'b0;
    total++; if (COUNT !== 5'd16) begin bad++; $display("FAIL full_push_pop_count got=%0d exp=16", COUNT); end
    total++; if (OVERFLOW !== 1'b0) begin bad++; $display("FAIL full_push_pop_ovf got=%b exp=0", OVERFLOW); end
    @(negedge CLK);
    for (int i = 0; i < 16; i++) begin
      exp_head = (i < 15) ? (11'h400 | 11'(i + 2)) : 11'h413;
      total++; if (RD_DATA !== exp_head) begin bad++; $display("FAIL drain_%0d got=%h exp=%h", i, RD_DATA, exp_head); end
      pop_one();
    end
    total++; if (COUNT !== 5'd0) begin bad++; $display("FAIL drain_count got=%0d exp=0", COUNT); end
    pop_one();
    total++; if (COUNT !== 5'd0) begin bad++; $display("FAIL empty_pop_count got=%0d exp=0", COUNT); end
    total++; if (RD_DATA !== 11'h000) begin bad++; $display("FAIL empty_pop_data got=%h exp=000", RD_DATA); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    send_byte(8'h1C, 1);
    send_byte(8'hE0, 1);
    #2 reset = 1'b1;
    @(negedge CLK);
    total++; if (RD_DATA !== 11'h000) begin bad++; $display("FAIL mid_reset_data got=%h exp=000", RD_DATA); end
    total++; if (INTR !== 1'b0) begin bad++; $display("FAIL mid_reset_intr got=%b exp=0", INTR); end
    total++; if (COUNT !== 5'd0) begin bad++; $display("FAIL mid_reset_count got=%0d exp=0", COUNT); end
    total++; if (OVERFLOW !== 1'b0) begin bad++; $display("FAIL mid_reset_ovf got=%b exp=0", OVERFLOW); end
    reset = 1'b0;
    @(negedge CLK);
    send_byte(8'h75, 1);
    total++; if (RD_DATA !== 11'h475) begin bad++; $display("FAIL post_reset_decode got=%h exp=475", RD_DATA); end
  endtask

  initial begin
    test_reset();
    test_long_strobe();
    test_break();
    test_extended();
    test_overflow();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
